// File: rtl/mapper_004.sv
// MMC3-style cartridge mapper: PRG/CHR bank switching, nametable mirroring,
// PRG-RAM protection and the PPU-A12 clocked scanline IRQ counter.
module mapper_004 #(
   parameter int PRG_ROM_DEPTH = 17,
   parameter int CHR_ROM_DEPTH = 15,
   parameter int PRG_RAM_DEPTH = 13
) (
   input  logic                     clk_cpu,
   input  logic                     rst_n,
   input  logic [14:0]              cpu_addr,
   input  logic [7:0]               cpu_data_i,
   input  logic                     cpu_rw,
   input  logic                     romsel,
   input  logic [13:0]              ppu_addr,
   input  logic                     mirrorv,
   input  logic                     chr_ram,
   input  logic                     prg_ram,
   input  logic [PRG_ROM_DEPTH-1:0] prg_mask,
   input  logic [CHR_ROM_DEPTH-1:0] chr_mask,
   input  logic [PRG_RAM_DEPTH-1:0] prgram_mask,
   output logic [PRG_ROM_DEPTH-1:0] prg_addr,
   output logic [CHR_ROM_DEPTH-1:0] chr_addr,
   output logic [PRG_RAM_DEPTH-1:0] prgram_addr,
   output logic                     prg_cs,
   output logic                     chr_cs,
   output logic                     prgram_cs,
   output logic [7:0]               mapper_reg_o,
   output logic                     ciram_ce,
   output logic                     ciram_a10,
   output logic                     irq
);

   localparam int PB = PRG_ROM_DEPTH - 13;
   localparam int PW = (PB > 8) ? PB : 8;
   localparam int CW = (CHR_ROM_DEPTH > 18) ? CHR_ROM_DEPTH : 18;
   localparam logic [PB-1:0] BANK_LAST = '1;
   localparam logic [PB-1:0] BANK_2ND  = BANK_LAST - PB'(1);

   typedef enum logic [2:0] {
      REG_BANK_SEL   = 3'b000,
      REG_BANK_DATA  = 3'b001,
      REG_MIRROR     = 3'b010,
      REG_PROTECT    = 3'b011,
      REG_IRQ_LATCH  = 3'b100,
      REG_IRQ_RELOAD = 3'b101,
      REG_IRQ_DIS    = 3'b110,
      REG_IRQ_EN     = 3'b111
   } reg_e;

   logic [7:0][7:0] r_q, r_d;
   logic [2:0]      target_q, target_d;
   logic            prg_mode_q, prg_mode_d;
   logic            chr_inv_q, chr_inv_d;
   logic            horiz_q, horiz_d;
   logic            mirror_wr_q, mirror_wr_d;
   logic            ram_en_q, ram_en_d;
   logic            ram_wp_q, ram_wp_d;
   logic [7:0]      latch_q, latch_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            reload_q, reload_d;
   logic            irq_en_q, irq_en_d;
   logic            pend_q, pend_d;
   logic [1:0]      low_cnt_q, low_cnt_d;

   logic            wr_en;
   reg_e            sel;
   logic            a12;
   logic            edge_cnt;
   logic            reload_wr;

   assign wr_en     = !romsel && !cpu_rw;
   assign sel       = reg_e'({cpu_addr[14:13], cpu_addr[0]});
   assign a12       = ppu_addr[12];
   // A rising A12 only clocks the counter after three or more low CPU cycles.
   assign edge_cnt  = a12 && (low_cnt_q == 2'd3);
   assign reload_wr = wr_en && (sel == REG_IRQ_RELOAD);

   always_comb begin
      r_d         = r_q;
      target_d    = target_q;
      prg_mode_d  = prg_mode_q;
      chr_inv_d   = chr_inv_q;
      horiz_d     = horiz_q;
      mirror_wr_d = mirror_wr_q;
      ram_en_d    = ram_en_q;
      ram_wp_d    = ram_wp_q;
      latch_d     = latch_q;
      cnt_d       = cnt_q;
      reload_d    = reload_q;
      irq_en_d    = irq_en_q;
      pend_d      = pend_q;
      low_cnt_d   = a12 ? 2'd0 : ((low_cnt_q == 2'd3) ? 2'd3 : low_cnt_q + 2'd1);

      if (edge_cnt && !reload_wr) begin
         if (cnt_q == 8'd0 || reload_q) begin
            cnt_d    = latch_q;
            reload_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
         if (cnt_d == 8'd0 && irq_en_q) pend_d = 1'b1;
      end

      // Register writes come last so that they win over same-cycle counter events.
      if (wr_en) begin
         case (sel)
            REG_BANK_SEL: begin
               target_d   = cpu_data_i[2:0];
               prg_mode_d = cpu_data_i[6];
               chr_inv_d  = cpu_data_i[7];
            end
            REG_BANK_DATA: r_d[target_q] = cpu_data_i;
            REG_MIRROR: begin
               mirror_wr_d = 1'b1;
               horiz_d     = cpu_data_i[0];
            end
            REG_PROTECT: begin
               ram_en_d = cpu_data_i[7];
               ram_wp_d = cpu_data_i[6];
            end
            REG_IRQ_LATCH: latch_d = cpu_data_i;
            REG_IRQ_RELOAD: begin
               cnt_d    = 8'd0;
               reload_d = 1'b1;
            end
            REG_IRQ_DIS: begin
               irq_en_d = 1'b0;
               pend_d   = 1'b0;
            end
            REG_IRQ_EN: irq_en_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= '0;
         target_q    <= '0;
         prg_mode_q  <= 1'b0;
         chr_inv_q   <= 1'b0;
         horiz_q     <= 1'b0;
         mirror_wr_q <= 1'b0;
         ram_en_q    <= 1'b1;
         ram_wp_q    <= 1'b0;
         latch_q     <= '0;
         cnt_q       <= '0;
         reload_q    <= 1'b0;
         irq_en_q    <= 1'b0;
         pend_q      <= 1'b0;
         low_cnt_q   <= '0;
      end else begin
         r_q         <= r_d;
         target_q    <= target_d;
         prg_mode_q  <= prg_mode_d;
         chr_inv_q   <= chr_inv_d;
         horiz_q     <= horiz_d;
         mirror_wr_q <= mirror_wr_d;
         ram_en_q    <= ram_en_d;
         ram_wp_q    <= ram_wp_d;
         latch_q     <= latch_d;
         cnt_q       <= cnt_d;
         reload_q    <= reload_d;
         irq_en_q    <= irq_en_d;
         pend_q      <= pend_d;
         low_cnt_q   <= low_cnt_d;
      end
   end

   logic [PW-1:0] r6_w, r7_w;
   logic [PB-1:0] bank;

   assign r6_w = PW'(r_q[6]);
   assign r7_w = PW'(r_q[7]);

   always_comb begin
      bank = BANK_LAST;
      case (cpu_addr[14:13])
         2'd0:    bank = prg_mode_q ? BANK_2ND : r6_w[PB-1:0];
         2'd1:    bank = r7_w[PB-1:0];
         2'd2:    bank = prg_mode_q ? r6_w[PB-1:0] : BANK_2ND;
         default: bank = BANK_LAST;
      endcase
   end

   assign prg_addr = {bank, cpu_addr[12:0]} & prg_mask;

   logic [CW-1:0] chr_full;

   // The low half (after inversion) uses two 2KB banks, the high half four 1KB banks.
   always_comb begin
      if (!(ppu_addr[12] ^ chr_inv_q))
         chr_full = CW'({r_q[{2'b00, ppu_addr[11]}][7:1], ppu_addr[10:0]});
      else
         chr_full = CW'({r_q[3'd2 + {1'b0, ppu_addr[11:10]}], ppu_addr[9:0]});
   end

   assign chr_addr = chr_full[CHR_ROM_DEPTH-1:0] & chr_mask;

   logic horizontal;
   assign horizontal = mirror_wr_q ? horiz_q : !mirrorv;

   assign prg_cs       = !romsel && cpu_rw;
   assign chr_cs       = !ppu_addr[13];
   assign ciram_ce     = ppu_addr[13];
   assign ciram_a10    = horizontal ? ppu_addr[11] : ppu_addr[10];
   assign mapper_reg_o = 8'h00;
   assign irq          = pend_q;
   assign prgram_cs    = romsel && (cpu_addr[14:13] == 2'b11) && prg_ram && ram_en_q &&
                         (cpu_rw || !ram_wp_q);
   assign prgram_addr  = PRG_RAM_DEPTH'(cpu_addr[12:0]) & prgram_mask;

   logic unused_bits;
   assign unused_bits = ^{chr_ram, r6_w, r7_w, chr_full};

endmodule

// File: tb/tb_mapper_004.sv
// Directed and randomized checks of mapper_004 against a behavioural model
// of the banking, mirroring, RAM-protect and scanline IRQ rules.
module tb_mapper_004;

   localparam int PD = 17;
   localparam int CD = 15;
   localparam int RD = 13;

   logic          clk_cpu = 1'b0;
   logic          rst_n;
   logic [14:0]   cpu_addr;
   logic [7:0]    cpu_data_i;
   logic          cpu_rw;
   logic          romsel;
   logic [13:0]   ppu_addr;
   logic          mirrorv;
   logic          chr_ram;
   logic          prg_ram;
   logic [PD-1:0] prg_mask;
   logic [CD-1:0] chr_mask;
   logic [RD-1:0] prgram_mask;
   logic [PD-1:0] prg_addr;
   logic [CD-1:0] chr_addr;
   logic [RD-1:0] prgram_addr;
   logic          prg_cs, chr_cs, prgram_cs;
   logic [7:0]    mapper_reg_o;
   logic          ciram_ce, ciram_a10, irq;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   int m_r[8];
   int m_target, m_prgmode, m_chrinv, m_mwr, m_horiz, m_ramen, m_wp;
   int m_latch, m_cnt, m_reload, m_irqen, m_pend, m_lowrun;

   mapper_004 #(.PRG_ROM_DEPTH(PD), .CHR_ROM_DEPTH(CD), .PRG_RAM_DEPTH(RD)) dut (
      .clk_cpu(clk_cpu), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
      .cpu_rw(cpu_rw), .romsel(romsel), .ppu_addr(ppu_addr), .mirrorv(mirrorv),
      .chr_ram(chr_ram), .prg_ram(prg_ram), .prg_mask(prg_mask), .chr_mask(chr_mask),
      .prgram_mask(prgram_mask), .prg_addr(prg_addr), .chr_addr(chr_addr),
      .prgram_addr(prgram_addr), .prg_cs(prg_cs), .chr_cs(chr_cs), .prgram_cs(prgram_cs),
      .mapper_reg_o(mapper_reg_o), .ciram_ce(ciram_ce), .ciram_a10(ciram_a10), .irq(irq)
   );

   always #5 clk_cpu = ~clk_cpu;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) m_r[k] = 0;
      m_target = 0; m_prgmode = 0; m_chrinv = 0; m_mwr = 0; m_horiz = 0;
      m_ramen = 1; m_wp = 0; m_latch = 0; m_cnt = 0; m_reload = 0;
      m_irqen = 0; m_pend = 0; m_lowrun = 0;
   endtask

   function automatic int exp_prg();
      int nb, slot, bank;
      nb   = 1 << (PD - 13);
      slot = (int'(cpu_addr) >> 13) & 3;
      case (slot)
         0:       bank = (m_prgmode != 0) ? nb - 2 : m_r[6];
         1:       bank = m_r[7];
         2:       bank = (m_prgmode != 0) ? m_r[6] : nb - 2;
         default: bank = nb - 1;
      endcase
      return ((bank % nb) * 8192 + int'(cpu_addr) % 8192) & int'(prg_mask);
   endfunction

   function automatic int exp_chr();
      int a, s, r, v;
      a = int'(ppu_addr);
      s = ((a >> 12) & 1) ^ m_chrinv;
      if (s == 0) begin
         r = (((a >> 11) & 1) != 0) ? m_r[1] : m_r[0];
         v = (r & 'hFE) * 1024 + a % 2048;
      end else begin
         v = m_r[2 + ((a >> 10) & 3)] * 1024 + a % 1024;
      end
      return v & int'(chr_mask);
   endfunction

   function automatic int exp_a10();
      int horiz;
      horiz = (m_mwr != 0) ? m_horiz : ((mirrorv == 1'b1) ? 0 : 1);
      return (horiz != 0) ? int'(ppu_addr[11]) : int'(ppu_addr[10]);
   endfunction

   function automatic int exp_prgram_cs();
      return (romsel == 1'b1 && ((int'(cpu_addr) >> 13) & 3) == 3 && prg_ram == 1'b1 &&
              m_ramen != 0 && (cpu_rw == 1'b1 || m_wp == 0)) ? 1 : 0;
   endfunction

   task automatic check_all();
      chk("prg_addr", 32'(prg_addr), exp_prg());
      chk("chr_addr", 32'(chr_addr), exp_chr());
      chk("prgram_addr", 32'(prgram_addr), (int'(cpu_addr) % 8192) & int'(prgram_mask));
      chk("prg_cs", 32'(prg_cs), (romsel == 1'b0 && cpu_rw == 1'b1) ? 1 : 0);
      chk("chr_cs", 32'(chr_cs), (ppu_addr[13] == 1'b0) ? 1 : 0);
      chk("ciram_ce", 32'(ciram_ce), int'(ppu_addr[13]));
      chk("ciram_a10", 32'(ciram_a10), exp_a10());
      chk("prgram_cs", 32'(prgram_cs), exp_prgram_cs());
      chk("mapper_reg_o", 32'(mapper_reg_o), 0);
      chk("irq", 32'(irq), m_pend);
   endtask

   // Applies the rules for one CPU bus cycle with the inputs currently driven.
   task automatic model_commit();
      int counted, wr, sel, d, n_cnt, n_reload, n_pend;
      counted  = (ppu_addr[12] == 1'b1 && m_lowrun >= 3) ? 1 : 0;
      m_lowrun = (ppu_addr[12] == 1'b1) ? 0 : m_lowrun + 1;
      wr       = (romsel == 1'b0 && cpu_rw == 1'b0) ? 1 : 0;
      sel      = ((int'(cpu_addr) >> 13) & 3) * 2 + int'(cpu_addr[0]);
      d        = int'(cpu_data_i);
      n_cnt = m_cnt; n_reload = m_reload; n_pend = m_pend;
      if (counted != 0 && !(wr != 0 && sel == 5)) begin
         if (m_cnt == 0 || m_reload != 0) begin
            n_cnt = m_latch; n_reload = 0;
         end else begin
            n_cnt = m_cnt - 1;
         end
         if (n_cnt == 0 && m_irqen != 0) n_pend = 1;
      end
      if (wr != 0) begin
         case (sel)
            0: begin m_target = d & 7; m_prgmode = (d >> 6) & 1; m_chrinv = (d >> 7) & 1; end
            1: m_r[m_target] = d;
            2: begin m_mwr = 1; m_horiz = d & 1; end
            3: begin m_ramen = (d >> 7) & 1; m_wp = (d >> 6) & 1; end
            4: m_latch = d;
            5: begin n_cnt = 0; n_reload = 1; end
            6: begin m_irqen = 0; n_pend = 0; end
            default: m_irqen = 1;
         endcase
      end
      m_cnt = n_cnt; m_reload = n_reload; m_pend = n_pend;
   endtask

   task automatic cyc();
      @(negedge clk_cpu);
      check_all();
      @(posedge clk_cpu);
      model_commit();
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a[14:0]; romsel = ~a[15]; cpu_rw = 1'b0; cpu_data_i = d;
      cyc();
   endtask

   task automatic rd(input logic [15:0] a);
      cpu_addr = a[14:0]; romsel = ~a[15]; cpu_rw = 1'b1;
      cyc();
   endtask

   task automatic pulse(input int nlow);
      cpu_addr = '0; romsel = 1'b1; cpu_rw = 1'b1;
      ppu_addr[12] = 1'b0;
      repeat (nlow) cyc();
      ppu_addr[12] = 1'b1;
      cyc();
      ppu_addr[12] = 1'b0;
   endtask

   task automatic do_reset_pulse();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_irq", 32'(irq), 0);
      check_all();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; mirrorv = 1'b1; chr_ram = 1'b0; prg_ram = 1'b1;
      prg_mask = '1; chr_mask = 15'h1FFF; prgram_mask = '1;
      cpu_addr = 15'h4123; romsel = 1'b0; cpu_rw = 1'b1; cpu_data_i = 8'h00; ppu_addr = '0;
      model_reset();

      // reset state: fixed banks, zeroed registers
      #2;
      check_all();
      chk("rst_prg_2nd_last", 32'(prg_addr), 32'h1C123);
      chk("rst_prg_cs", 32'(prg_cs), 1);
      chk("rst_irq", 32'(irq), 0);
      cpu_addr = 15'h7FFF;
      #1;
      check_all();
      chk("rst_prg_last", 32'(prg_addr), 32'h1FFFF);
      @(posedge clk_cpu);
      #1;
      rst_n = 1'b1;

      // PRG banking in both modes
      wr(16'h8000, 8'h46); wr(16'h8001, 8'h05);
      rd(16'hC010); chk("prg_mode1_r6", 32'(prg_addr), 32'h0A010);
      rd(16'h8010); chk("prg_mode1_2nd_last", 32'(prg_addr), 32'h1C010);
      wr(16'h8000, 8'h06);
      rd(16'h8010); chk("prg_mode0_r6", 32'(prg_addr), 32'h0A010);

      // CHR banking with inversion and masking
      wr(16'h8000, 8'h80); wr(16'h8001, 8'h0C);
      ppu_addr = 14'h1456;
      rd(16'h8000); chk("chr_inv_r0_mask", 32'(chr_addr), 32'h1456);
      chr_mask = 15'h7FFF;
      #1;
      chk("chr_inv_r0_full", 32'(chr_addr), 32'h3456);
      check_all();

      // mirroring control
      ppu_addr = 14'h2800;
      rd(16'h8000); chk("mirror_default_v", 32'(ciram_a10), 0);
      wr(16'hA000, 8'h01);
      rd(16'h8000); chk("mirror_horiz", 32'(ciram_a10), 1);

      // PRG-RAM protection
      wr(16'hA001, 8'hC0);
      cpu_addr = 15'h6000; romsel = 1'b1; cpu_rw = 1'b0;
      #1;
      chk("ram_wp_write", 32'(prgram_cs), 0);
      cyc();
      rd(16'h6000); chk("ram_wp_read", 32'(prgram_cs), 1);
      wr(16'hA001, 8'h00);
      rd(16'h6000); chk("ram_disabled_read", 32'(prgram_cs), 0);
      wr(16'hA001, 8'h80);

      // scanline IRQ: latch=3, four counted edges
      ppu_addr = 14'h0000;
      wr(16'hC000, 8'h03); wr(16'hC001, 8'h00); wr(16'hE001, 8'h00);
      repeat (3) pulse(4);
      chk("irq_before_4th", 32'(irq), 0);
      pulse(4);
      chk("irq_after_4th", 32'(irq), 1);
      wr(16'hE000, 8'h00);
      chk("irq_ack", 32'(irq), 0);
      wr(16'hE001, 8'h00);
      repeat (10) pulse(1);
      chk("irq_short_pulses", 32'(irq), 0);

      // disable write beats a same-cycle pending set
      wr(16'hC000, 8'h01); wr(16'hC001, 8'h00);
      pulse(4);
      ppu_addr[12] = 1'b0;
      cpu_addr = '0; romsel = 1'b1; cpu_rw = 1'b1;
      repeat (4) cyc();
      ppu_addr[12] = 1'b1;
      wr(16'hE000, 8'h00);
      ppu_addr[12] = 1'b0;
      chk("irq_disable_wins", 32'(irq), 0);

      // reload write overrides a same-cycle counted edge
      wr(16'hE001, 8'h00); wr(16'hC001, 8'h00);
      pulse(4);
      cpu_addr = '0; romsel = 1'b1; cpu_rw = 1'b1;
      repeat (4) cyc();
      ppu_addr[12] = 1'b1;
      wr(16'hC001, 8'h00);
      ppu_addr[12] = 1'b0;
      chk("irq_reload_override", 32'(irq), 0);
      pulse(4);
      chk("irq_after_reload", 32'(irq), 0);
      pulse(4);
      chk("irq_count_resumes", 32'(irq), 1);
      wr(16'hE000, 8'h00);

      // reset in the middle of a count
      wr(16'hC000, 8'h05); wr(16'hC001, 8'h00); wr(16'hE001, 8'h00);
      pulse(4); pulse(4);
      do_reset_pulse();
      repeat (6) pulse(4);
      chk("irq_after_midreset", 32'(irq), 0);

      // randomized bus and PPU traffic
      for (int i = 0; i < 500; i++) begin
         if (i % 64 == 0) begin
            prg_mask    = PD'($urandom) | PD'(17'h18000);
            chr_mask    = CD'($urandom);
            prgram_mask = RD'($urandom);
            mirrorv     = 1'($urandom);
            prg_ram     = ($urandom_range(0, 3) != 0);
         end
         if (i == 250) do_reset_pulse();
         cpu_addr   = 15'($urandom);
         romsel     = 1'($urandom);
         cpu_rw     = 1'($urandom);
         cpu_data_i = 8'($urandom);
         if (!romsel && !cpu_rw && {cpu_addr[14:13], cpu_addr[0]} == 3'b100)
            cpu_data_i = 8'($urandom_range(0, 3));
         ppu_addr     = 14'($urandom);
         ppu_addr[12] = ($urandom_range(0, 4) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
